// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB3-to-AXI4 bridge.
// Holds the FSM state encoding and the AXI response/size codes.
package apb2axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WRESP,
        ST_RD,
        ST_RDATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY:   err = 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
            default:                          err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/apb2axi_lane.sv
// Steers a 32-bit APB word into/out of the 32-bit lane of a wider AXI data bus.
// Write data is replicated into every lane; only the selected lane is strobed.
module apb2axi_lane #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int LANE_W         = 1
) (
    input  logic [LANE_W-1:0]           i_lane,
    input  logic [31:0]                 i_wdata,
    input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
    output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
    output logic [31:0]                 o_rdata
);

    localparam int NLANES = AXI_DATA_WIDTH / 32;

    always_comb begin
        o_wdata = {NLANES{i_wdata}};
        o_wstrb = '0;
        o_rdata = '0;
        for (int l = 0; l < NLANES; l++) begin
            if (i_lane == l[LANE_W-1:0]) begin
                o_wstrb[4*l +: 4] = 4'hF;
                o_rdata           = i_rdata[32*l +: 32];
            end
        end
    end

endmodule

// File: rtl/apb2axi.sv
// APB3 completer to AXI4 manager bridge: each APB access becomes one
// single-beat 32-bit AXI transaction, with pready held low until the response.
module apb2axi
    import apb2axi_pkg::*;
#(
    parameter int                        AXI_ID_WIDTH   = 6,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR  = 'h1A10_0000,
    parameter logic [AXI_ID_WIDTH-1:0]   AXI_TXN_ID     = '0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [APB_ADDR_WIDTH-1:0]   paddr,
    input  logic [31:0]                 pwdata,
    output logic [31:0]                 prdata,
    output logic                        pready,
    output logic                        pslverr,
    output logic [AXI_ID_WIDTH-1:0]     AWID,
    output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    output logic [7:0]                  AWLEN,
    output logic [2:0]                  AWSIZE,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]   WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    output logic                        WLAST,
    output logic                        WVALID,
    input  logic                        WREADY,
    input  logic [AXI_ID_WIDTH-1:0]     BID,
    input  logic [1:0]                  BRESP,
    input  logic                        BVALID,
    output logic                        BREADY,
    output logic [AXI_ID_WIDTH-1:0]     ARID,
    output logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    output logic [7:0]                  ARLEN,
    output logic [2:0]                  ARSIZE,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]     RID,
    input  logic [AXI_DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]                  RRESP,
    input  logic                        RLAST,
    input  logic                        RVALID,
    output logic                        RREADY
);

    localparam int NLANES = AXI_DATA_WIDTH / 32;
    localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK =
        (AXI_ADDR_WIDTH'(1) << APB_ADDR_WIDTH) - AXI_ADDR_WIDTH'(1);

    state_t                      r_state;
    logic [AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]                 r_wdata;
    logic                        r_awvalid;
    logic                        r_wvalid;
    logic                        r_arvalid;
    logic                        r_bready;
    logic                        r_rready;
    logic                        r_pready;
    logic                        r_pslverr;
    logic [31:0]                 r_prdata;

    logic [AXI_ADDR_WIDTH-1:0]   w_req_addr;
    logic [LANE_W-1:0]           w_lane;
    logic [31:0]                 w_rdata32;
    logic                        w_unused;

    assign w_req_addr = ((AXI_BASE_ADDR & ~LOW_MASK) | AXI_ADDR_WIDTH'(paddr))
                        & ~AXI_ADDR_WIDTH'(3);

    generate
        if (NLANES > 1) begin : g_lane
            assign w_lane = r_addr[2 +: LANE_W];
        end else begin : g_nolane
            assign w_lane = '0;
        end
    endgenerate

    apb2axi_lane #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .LANE_W         (LANE_W)
    ) u_lane (
        .i_lane  (w_lane),
        .i_wdata (r_wdata),
        .i_rdata (RDATA),
        .o_wdata (WDATA),
        .o_wstrb (WSTRB),
        .o_rdata (w_rdata32)
    );

    // Response IDs and RLAST carry no information for single-beat, single-ID traffic.
    assign w_unused = &{1'b0, BID, RID, RLAST};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_rready  <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (psel && penable) begin
                        r_addr  <= w_req_addr;
                        r_wdata <= pwdata;
                        if (pwrite) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    // AW and W complete independently; a channel already done reads as ready.
                    if (AWREADY) r_awvalid <= 1'b0;
                    if (WREADY)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || AWREADY) && (!r_wvalid || WREADY)) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (BVALID) begin
                        r_bready  <= 1'b0;
                        r_pslverr <= resp_is_err(BRESP);
                        r_pready  <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_RD: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (RVALID) begin
                        r_rready  <= 1'b0;
                        r_prdata  <= w_rdata32;
                        r_pslverr <= resp_is_err(RRESP);
                        r_pready  <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign AWID    = AXI_TXN_ID;
    assign ARID    = AXI_TXN_ID;
    assign AWADDR  = r_addr;
    assign ARADDR  = r_addr;
    assign AWLEN   = 8'd0;
    assign ARLEN   = 8'd0;
    assign AWSIZE  = AXI_SIZE_4B;
    assign ARSIZE  = AXI_SIZE_4B;
    assign WLAST   = 1'b1;
    assign AWVALID = r_awvalid;
    assign WVALID  = r_wvalid;
    assign ARVALID = r_arvalid;
    assign BREADY  = r_bready;
    assign RREADY  = r_rready;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule

// File: tb/tb_apb2axi.sv
// Directed testbench for apb2axi: APB agent and AXI slave are driven by hand
// from scenario tasks, each comparing outputs against hand-computed values.
module tb_apb2axi;

    logic        clk;
    logic        rstn;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [5:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY, ARVALID, ARREADY, RLAST, RVALID, RREADY;

    int n_chk  = 0;
    int n_fail = 0;

    apb2axi dut (
        .clk     (clk),     .rstn    (rstn),
        .psel    (psel),    .penable (penable), .pwrite (pwrite),
        .paddr   (paddr),   .pwdata  (pwdata),  .prdata (prdata),
        .pready  (pready),  .pslverr (pslverr),
        .AWID    (AWID),    .AWADDR  (AWADDR),  .AWLEN  (AWLEN),
        .AWSIZE  (AWSIZE),  .AWVALID (AWVALID), .AWREADY(AWREADY),
        .WDATA   (WDATA),   .WSTRB   (WSTRB),   .WLAST  (WLAST),
        .WVALID  (WVALID),  .WREADY  (WREADY),
        .BID     (BID),     .BRESP   (BRESP),   .BVALID (BVALID), .BREADY (BREADY),
        .ARID    (ARID),    .ARADDR  (ARADDR),  .ARLEN  (ARLEN),
        .ARSIZE  (ARSIZE),  .ARVALID (ARVALID), .ARREADY(ARREADY),
        .RID     (RID),     .RDATA   (RDATA),   .RRESP  (RRESP),
        .RLAST   (RLAST),   .RVALID  (RVALID),  .RREADY (RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Generic APB transfer against an AXI slave with ready always high and
    // the B/R response delayed 'dly' cycles after BREADY/RREADY rises.
    task automatic xfer(input string nm, input logic wr, input logic [11:0] addr,
                        input logic [31:0] wd, input int dly, input logic [1:0] resp,
                        input logic [63:0] rd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic [31:0] exp_addr);
        int k, rc;
        logic done, v;
        logic [31:0] got;
        AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
        BVALID = 1'b0; RVALID = 1'b0;
        BRESP = resp; RRESP = resp; RDATA = rd;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        k = 0; rc = 0; done = 1'b0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            n_chk++;
            if ((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)) begin
                n_fail++;
                $display("FAIL %s_exclusive cycle %0d: aw=%0b w=%0b b=%0b ar=%0b r=%0b required no overlap",
                         nm, k, AWVALID, WVALID, BREADY, ARVALID, RREADY);
            end
            if (k == 1) begin
                got = wr ? AWADDR : ARADDR;
                v   = wr ? (AWVALID && WVALID) : ARVALID;
                n_chk++;
                if (v !== 1'b1 || got !== exp_addr) begin
                    n_fail++;
                    $display("FAIL %s_addr: valid=%0b addr=%h required valid=1 addr=%h", nm, v, got, exp_addr);
                end
            end
            if (pready === 1'b1) begin
                done = 1'b1;
            end else begin
                if (BREADY || RREADY) rc++;
                BVALID = wr && (rc > dly);
                RVALID = !wr && (rc > dly);
            end
        end
        BVALID = 1'b0; RVALID = 1'b0;
        n_chk++;
        if (!done || k != 3 + dly) begin
            n_fail++;
            $display("FAIL %s_latency: pready seen=%0b at cycle %0d required cycle %0d", nm, done, k, 3 + dly);
        end
        n_chk++;
        if (pslverr !== exp_err) begin
            n_fail++;
            $display("FAIL %s_pslverr: got %0b required %0b", nm, pslverr, exp_err);
        end
        if (!wr) begin
            n_chk++;
            if (prdata !== exp_rd) begin
                n_fail++;
                $display("FAIL %s_prdata: got %h required %h", nm, prdata, exp_rd);
            end
        end
        @(negedge clk);
        n_chk++;
        if (pready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pready_pulse: got %0b required 0", nm, pready);
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
        BID = '0; RID = '0; BRESP = '0; RRESP = '0; BVALID = 1'b0;
        RDATA = '0; RLAST = 1'b1; RVALID = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_axi_handshake: got %b required 00000", {AWVALID, WVALID, ARVALID, BREADY, RREADY});
        end
        n_chk++;
        if (pready !== 1'b0 || pslverr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_apb_status: pready=%0b pslverr=%0b required 0 0", pready, pslverr);
        end
        n_chk++;
        if (prdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_prdata: got %h required 00000000", prdata);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_zero_wait();
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'b00;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hDEADBEEF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        n_chk++;
        if (AWVALID !== 1'b1 || WVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_valids_a1: aw=%0b w=%0b required 1 1", AWVALID, WVALID);
        end
        n_chk++;
        if (AWADDR !== 32'h1A10_0004) begin
            n_fail++;
            $display("FAIL wr_awaddr: got %h required 1a100004", AWADDR);
        end
        n_chk++;
        if (WSTRB !== 8'hF0) begin
            n_fail++;
            $display("FAIL wr_wstrb: got %h required f0", WSTRB);
        end
        n_chk++;
        if (WDATA !== 64'hDEADBEEF_DEADBEEF) begin
            n_fail++;
            $display("FAIL wr_wdata: got %h required deadbeefdeadbeef", WDATA);
        end
        n_chk++;
        if (AWLEN !== 8'd0 || AWSIZE !== 3'b010 || WLAST !== 1'b1 || AWID !== 6'd0) begin
            n_fail++;
            $display("FAIL wr_attrs: len=%h size=%b wlast=%0b id=%h required 00 010 1 00", AWLEN, AWSIZE, WLAST, AWID);
        end
        n_chk++;
        if (pready !== 1'b0 || BREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_a1_wait: pready=%0b bready=%0b required 0 0", pready, BREADY);
        end
        @(negedge clk);
        n_chk++;
        if (AWVALID !== 1'b0 || WVALID !== 1'b0 || BREADY !== 1'b1 || pready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_a2: aw=%0b w=%0b bready=%0b pready=%0b required 0 0 1 0", AWVALID, WVALID, BREADY, pready);
        end
        BVALID = 1'b1;
        @(negedge clk);
        BVALID = 1'b0;
        n_chk++;
        if (pready !== 1'b1 || pslverr !== 1'b0 || BREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_a3_done: pready=%0b pslverr=%0b bready=%0b required 1 0 0", pready, pslverr, BREADY);
        end
        @(negedge clk);
        n_chk++;
        if (pready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_pready_pulse: got %0b required 0", pready);
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_read_lanes();
        xfer("rd_lane0", 1'b0, 12'h010, 32'h0, 0, 2'b00, 64'h1111_2222_3333_4444,
             32'h3333_4444, 1'b0, 32'h1A10_0010);
        xfer("rd_lane1", 1'b0, 12'h014, 32'h0, 0, 2'b00, 64'hAAAA_BBBB_CCCC_DDDD,
             32'hAAAA_BBBB, 1'b0, 32'h1A10_0014);
        xfer("rd_addr_lsb", 1'b0, 12'hFFF, 32'h0, 0, 2'b00, 64'h0123_4567_89AB_CDEF,
             32'h0123_4567, 1'b0, 32'h1A10_0FFC);
    endtask

    task automatic test_aw_skew();
        AWREADY = 1'b0; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'b00;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h1234_5678;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        n_chk++;
        if (AWVALID !== 1'b1 || WVALID !== 1'b1 || WSTRB !== 8'h0F) begin
            n_fail++;
            $display("FAIL skew_a1: aw=%0b w=%0b strb=%h required 1 1 0f", AWVALID, WVALID, WSTRB);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (WVALID !== 1'b0 || AWVALID !== 1'b1 || AWADDR !== 32'h1A10_0008 ||
                BREADY !== 1'b0 || pready !== 1'b0) begin
                n_fail++;
                $display("FAIL skew_hold_%0d: w=%0b aw=%0b addr=%h bready=%0b pready=%0b required 0 1 1a100008 0 0",
                         i, WVALID, AWVALID, AWADDR, BREADY, pready);
            end
        end
        AWREADY = 1'b1;
        @(negedge clk);
        n_chk++;
        if (AWVALID !== 1'b0 || BREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL skew_aw_done: aw=%0b bready=%0b required 0 1", AWVALID, BREADY);
        end
        BVALID = 1'b1;
        @(negedge clk);
        BVALID = 1'b0;
        n_chk++;
        if (pready !== 1'b1 || pslverr !== 1'b0) begin
            n_fail++;
            $display("FAIL skew_done: pready=%0b pslverr=%0b required 1 0", pready, pslverr);
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_error_resp();
        xfer("err_wr_slverr", 1'b1, 12'h100, 32'hCAFE_0001, 0, 2'b10, 64'h0, 32'h0, 1'b1, 32'h1A10_0100);
        xfer("err_rd_decerr", 1'b0, 12'h104, 32'h0, 0, 2'b11, 64'h5555_6666_7777_8888,
             32'h5555_6666, 1'b1, 32'h1A10_0104);
        xfer("err_wr_exokay", 1'b1, 12'h108, 32'hCAFE_0002, 0, 2'b01, 64'h0, 32'h0, 1'b0, 32'h1A10_0108);
        xfer("err_rd_exokay", 1'b0, 12'h10C, 32'h0, 0, 2'b01, 64'h9999_AAAA_BBBB_CCCC,
             32'h9999_AAAA, 1'b0, 32'h1A10_010C);
    endtask

    task automatic test_back_to_back();
        xfer("b2b_rd", 1'b0, 12'h020, 32'h0, 3, 2'b00, 64'hFEDC_BA98_7654_3210,
             32'h7654_3210, 1'b0, 32'h1A10_0020);
        xfer("b2b_wr", 1'b1, 12'h024, 32'h0BAD_F00D, 3, 2'b00, 64'h0, 32'h0, 1'b0, 32'h1A10_0024);
    endtask

    task automatic test_reset_mid();
        ARREADY = 1'b0; RVALID = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h030;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ARVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_arvalid_before: got %0b required 1", ARVALID);
        end
        #2 rstn = 1'b0;
        #1;
        n_chk++;
        if (ARVALID !== 1'b0 || RREADY !== 1'b0 || pready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: arvalid=%0b rready=%0b pready=%0b required 0 0 0", ARVALID, RREADY, pready);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        xfer("rstmid_next", 1'b0, 12'h030, 32'h0, 0, 2'b00, 64'h1357_9BDF_2468_ACE0,
             32'h2468_ACE0, 1'b0, 32'h1A10_0030);
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_lanes();
        test_aw_skew();
        test_error_resp();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb2axi.md
Name: apb2axi

Overview:
- APB3 completer (slave) to AXI4 manager (master) bridge. It is the reverse of the team's AXI-to-APB bridge.
- Lets an APB-side agent (debug port, boot controller) reach the AXI interconnect.
- Each APB access becomes exactly one single-beat, 32-bit AXI transaction. APB wait states (pready low) are inserted until the AXI response returns.

Parameters:
- AXI_ID_WIDTH, 6, width of AWID/ARID/BID/RID
- AXI_ADDR_WIDTH, 32, AXI address width
- AXI_DATA_WIDTH, 64, AXI data width; allowed values 32/64/128/256
- APB_ADDR_WIDTH, 12, APB address width; must be ≤ AXI_ADDR_WIDTH
- AXI_BASE_ADDR, 32'h1A10_0000, upper address bits prepended to paddr
- AXI_TXN_ID, 0, constant ID driven on AWID/ARID

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- psel, penable, pwrite  in  1 each  APB control
- paddr  in  APB_ADDR_WIDTH  APB address
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error
- AWID/ARID  out  AXI_ID_WIDTH; AWADDR/ARADDR  out  AXI_ADDR_WIDTH; AWLEN/ARLEN  out  8; AWSIZE/ARSIZE  out  3; AWVALID/ARVALID  out  1; AWREADY/ARREADY  in  1
- WDATA  out  AXI_DATA_WIDTH; WSTRB  out  AXI_DATA_WIDTH/8; WLAST, WVALID  out  1; WREADY  in  1
- BID  in  AXI_ID_WIDTH; BRESP  in  2; BVALID  in  1; BREADY  out  1
- RID  in  AXI_ID_WIDTH; RDATA  in  AXI_DATA_WIDTH; RRESP  in  2; RLAST, RVALID  in  1; RREADY  out  1

Behaviour:
- Interface: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values: all VALID/READY outputs 0, pready 0, pslverr 0, prdata 0, state IDLE.
- Address and data mapping:
  - AxADDR = AXI_BASE_ADDR with the low APB_ADDR_WIDTH bits replaced by paddr, and bits [1:0] forced to 0.
  - AxLEN = 0, AxSIZE = 3'b010, WLAST = 1.
  - Lane L = AxADDR[2 +: log2(AXI_DATA_WIDTH/32)]; L = 0 when AXI_DATA_WIDTH = 32.
  - WDATA = pwdata replicated into every 32-bit lane. WSTRB = 4'hF in lane L, 0 elsewhere.
  - prdata captures RDATA[32*L +: 32].
- Request capture: address, data and direction are registered on the first cycle with psel & penable & state == IDLE (APB access phase). The setup phase is ignored.
- FSM states and transitions:
  - IDLE: on access phase, go to WR if pwrite, else RD.
  - WR: AWVALID and WVALID rise in the cycle after capture. Each drops independently after its own handshake. Go to WRESP once both handshakes are done; they may complete in either order or the same cycle.
  - WRESP: BREADY = 1. On BVALID, latch err = BRESP[1] and go to DONE.
  - RD: ARVALID = 1 until ARREADY, then go to RDATA.
  - RDATA: RREADY = 1. On RVALID, latch prdata and err = RRESP[1], then go to DONE.
  - DONE: pready = 1 and pslverr = err for exactly one cycle, then IDLE.
- VALID signals never drop before their handshake. Payload is stable while VALID is high.
- Minimum latency, zero-wait AXI slave, access phase at cycle A:
  - VALIDs high at A+1, handshake at A+1.
  - B/R handshake at A+2.
  - pready at A+3.
- pready stays low while the state is not DONE, so the APB agent holds its access phase.
- EXOKAY and OKAY both map to pslverr = 0. SLVERR and DECERR map to pslverr = 1.
- Exactly one outstanding AXI transaction at any time. No AW/AR issue while busy.
- If psel drops mid-transfer (an APB violation), the AXI transaction still completes. pready is pulsed in DONE regardless.
- Async reset mid-transaction drops all VALIDs at once and returns to IDLE. The AXI-side response is lost. This is acceptable only under a system-wide reset.
- BID/RID/RLAST are not checked.

Decomposition:
- apb2axi_pkg: state enum (IDLE, WR, WRESP, RD, RDATA, DONE), AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants, AXI_SIZE_4B constant.
- Sub-module apb2axi_lane: combinational lane steering (WDATA/WSTRB generation and RDATA extraction by L). Everything else stays in the top.

Test Plan:
- Write, zero-wait slave, DATA 64: paddr 12'h004, pwdata 32'hDEADBEEF → AWADDR 32'h1A10_0004, WSTRB 8'hF0, WDATA[63:32] = DEADBEEF, pready at A+3, pslverr 0.
- Read, lane 0: paddr 12'h010, RDATA 64'h1111_2222_3333_4444 → ARADDR 32'h1A10_0010, prdata 32'h3333_4444, pready one cycle only.
- AW/W skew: AWREADY delayed 5 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID held with stable AWADDR, BREADY asserts only after AW handshake.
- Error response: BRESP 2'b10 on write, then RRESP 2'b11 on read → pslverr 1 in each DONE cycle. EXOKAY → pslverr 0.
- Back-to-back: read then write in consecutive APB transfers with BVALID/RVALID delayed 3 cycles → never more than one VALID group active, pready low throughout each wait.
- Reset mid-transfer: rstn low while ARVALID high → ARVALID 0 immediately (asynchronous), FSM IDLE, next access completes normally.
